pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register for the pipelined MIPS core, the successor to the fixed seven-field stage register. It carries an arbitrary-width payload between two pipeline stages using a valid/ready handshake instead of a plain enable. A one-entry skid buffer keeps full throughput under back-pressure, and every cleared slot holds all-zero data, so a flushed or drained slot presents a MIPS NOP (instruction word 0). It sits between any two of the IF/ID/EX/MEM/WB stages, and the hazard unit drives `flush`.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_sat_counter.sv | 21 ++
 rtl/pipe_stage_buf.sv | 98 +++++++++
 tb/tb_pipe_stage_buf.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,
        PS_FULL  = 2'b01,
        PS_SKID  = 2'b10
    } pipe_state_t;

    // A cleared stage field reads as a MIPS NOP.
    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count visible the cycle after the increment edge.
// Backpressure: none; holds at all-ones instead of wrapping.
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with one-entry skid buffer; PIPE_STAGE_STATS_EN adds stall/bubble counters.
// Latency: 1 cycle in to out; full throughput while out_ready stays high.
// Backpressure: absorbs one extra beat in the skid register, then drops in_ready.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 224,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    localparam int NOP_WORDS = (DATA_W + 31) / 32;
    localparam logic [NOP_WORDS*32-1:0] NOP_FILL = {NOP_WORDS{PIPE_NOP}};
    localparam logic [DATA_W-1:0] CLR_DAT = NOP_FILL[DATA_W-1:0];

    logic [1:0]        state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_xfer;
    logic              out_xfer;

    // The unused encoding 2'b11 behaves exactly like EMPTY.
    assign out_valid = (state_q == PS_FULL) || (state_q == PS_SKID);
    assign in_ready  = (state_q != PS_SKID);
    assign out_data  = main_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= PS_EMPTY;
            main_q  <= CLR_DAT;
            skid_q  <= CLR_DAT;
        end else begin
            case (state_q)
                PS_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (out_xfer) begin
                        main_q  <= CLR_DAT;
                        state_q <= PS_EMPTY;
                    end else if (in_xfer) begin
                        skid_q  <= in_data;
                        state_q <= PS_SKID;
                    end
                end
                PS_SKID: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        skid_q  <= CLR_DAT;
                        state_q <= PS_FULL;
                    end
                end
                default: begin
                    if (in_xfer) begin
                        main_q  <= in_data;
                        state_q <= PS_FULL;
                    end else begin
                        state_q <= PS_EMPTY;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // Counters survive flush; only reset clears them.
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (reset),
        .inc (out_valid && !out_ready),
        .cnt (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .clr (reset),
        .inc (!out_valid && out_ready),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized and directed checks of pipe_stage_buf against a queue-based model (wide and 1-bit instances).
module tb_pipe_stage_buf;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_data1;
    logic          in_ready, out_valid, in_ready1, out_valid1;
    logic [DW-1:0] out_data;
    logic          out_data1;
`ifdef PIPE_STAGE_STATS_EN
    logic [CW-1:0] stall_cnt, bubble_cnt, stall_cnt1, bubble_cnt1;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .CNT_W(CW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    pipe_stage_buf #(.DATA_W(1), .CNT_W(CW)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .out_data  (out_data1)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt1),
        .bubble_cnt(bubble_cnt1)
`endif
    );

    // Model: an ordered queue of at most two entries; bit DW carries the 1-bit instance payload.
    logic [DW:0] mq[$];
    int          stall_m, bubble_m;
    int          n_cmp, n_bad;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [DW:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        chk("out_valid",  64'(out_valid),  64'(mq.size() != 0));
        chk("in_ready",   64'(in_ready),   64'(mq.size() < 2));
        chk("out_data",   64'(out_data),   64'(head[DW-1:0]));
        chk("out_valid1", 64'(out_valid1), 64'(mq.size() != 0));
        chk("in_ready1",  64'(in_ready1),  64'(mq.size() < 2));
        chk("out_data1",  64'(out_data1),  64'(head[DW]));
`ifdef PIPE_STAGE_STATS_EN
        chk("stall_cnt",   64'(stall_cnt),   64'(stall_m));
        chk("bubble_cnt",  64'(bubble_cnt),  64'(bubble_m));
        chk("stall_cnt1",  64'(stall_cnt1),  64'(stall_m));
        chk("bubble_cnt1", 64'(bubble_cnt1), 64'(bubble_m));
`endif
    endtask

    // One clock: check current outputs, drive inputs, advance the model at the edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic d1,
                        input logic ordy, input logic fl, input logic rst);
        logic ov, in_x, out_x;
        @(negedge clk);
        check_outputs();
        in_valid  = iv;
        in_data   = d;
        in_data1  = d1;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        ov    = (mq.size() != 0);
        in_x  = iv && (mq.size() < 2);
        out_x = ov && ordy;
        @(posedge clk);
        if (rst) begin
            stall_m  = 0;
            bubble_m = 0;
        end else begin
            if (ov && !ordy && stall_m < CNT_MAX) stall_m++;
            if (!ov && ordy && bubble_m < CNT_MAX) bubble_m++;
        end
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (out_x) void'(mq.pop_front());
            if (in_x) mq.push_back({d1, d});
        end
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; stall_m = 0; bubble_m = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_data1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_data",  64'(out_data),  64'd0);
        @(posedge clk);
        bubble_m = 0;  // out_ready held 0 above, so no bubbles counted

        // Streaming
        step(1'b1, 16'h0011, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0033, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("stream_last", 64'(out_data), 64'h33);
        idle(1'b1, 2);

        // Back-pressure into SKID, then drain in order
        step(1'b1, 16'h00A1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00A2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00A3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 3);

        // Flush while in SKID with a concurrent input
        step(1'b1, 16'h00C1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00C2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00BB, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_data",  64'(out_data),  64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        idle(1'b1, 2);

        // Reset beats flush and input
        step(1'b1, 16'h00D1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00D2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00D3, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("rstpri_out_valid", 64'(out_valid), 64'd0);
        chk("rstpri_out_data",  64'(out_data),  64'd0);
        chk("rstpri_in_ready",  64'(in_ready),  64'd1);

        // Saturation under long back-pressure, unaffected by flush
        step(1'b1, 16'h00E1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 20);
`ifdef PIPE_STAGE_STATS_EN
        @(negedge clk);
        chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
`endif
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1);
`ifdef PIPE_STAGE_STATS_EN
        @(negedge clk);
        chk("stall_after_flush", 64'(stall_cnt), 64'(CNT_MAX));
`endif
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 99) == 0));
        end
        @(negedge clk);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
